zone_pump_scheduler: RTL and testbench

//  Shares the single irrigation pump between N_ZONES zone requesters.

---
 rtl/zone_pump_scheduler.sv | 171 +++++++++++++++++
 tb/tb_zone_pump_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_pump_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : zone_pump_scheduler                                        |
// | Description : Round-robin sharing of one irrigation pump between zones.  |
// |               Each grant runs FILL -> IRRIGATE -> CLEAN, timed by the    |
// |               1 Hz tick.                                                 |
// | Option      : PRIORITY_ZONE0_EN - zone 0 request wins over the RR scan.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module zone_pump_scheduler #(
    parameter int N_ZONES    = 4,
    parameter int FILL_SECS  = 5,
    parameter int IRR_SECS   = 10,
    parameter int CLEAN_SECS = 3
) (
    input  logic               clk_50mhz,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               enable,
    input  logic [N_ZONES-1:0] req,
    input  logic               abort,
    output logic [N_ZONES-1:0] grant,
    output logic               pump_on,
    output logic               valve_clean,
    output logic [1:0]         phase,
    output logic [7:0]         secs_left,
    output logic               done
);

    localparam int LW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

    localparam logic [7:0]    c_FILL_LEN  = 8'(FILL_SECS);
    localparam logic [7:0]    c_IRR_LEN   = 8'(IRR_SECS);
    localparam logic [7:0]    c_CLEAN_LEN = 8'(CLEAN_SECS);
    localparam logic [LW-1:0] c_LAST_RST  = LW'(N_ZONES - 1);

    typedef enum logic [1:0] {
        c_IDLE  = 2'b00,
        c_FILL  = 2'b01,
        c_IRR   = 2'b10,
        c_CLEAN = 2'b11
    } phase_t;

    phase_t             r_phase_q,  w_phase_d;
    logic [N_ZONES-1:0] r_grant_q,  w_grant_d;
    logic [7:0]         r_secs_q,   w_secs_d;
    logic [LW-1:0]      r_last_q,   w_last_d;
    logic               r_done_q,   w_done_d;
    logic               r_pump_q,   w_pump_d;
    logic               r_clean_q,  w_clean_d;

    logic [LW-1:0]      w_winner;
    logic               w_found;
    logic               w_upd_last;
    logic               w_req_lost;

    // Pick the next zone: first active request after the last winner, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        w_winner   = '0;
        w_found    = 1'b0;
        w_upd_last = 1'b1;
        for (int i = 1; i <= N_ZONES; i++) begin
            idx = int'(r_last_q) + i;
            if (idx >= N_ZONES) begin
                idx = idx - N_ZONES;
            end
            if (!w_found && req[LW'(idx)]) begin
                w_found  = 1'b1;
                w_winner = LW'(idx);
            end
        end
`ifdef PRIORITY_ZONE0_EN
        // Zone 0 pre-empts the scan and leaves the pointer where it was.
        if (req[0]) begin
            w_winner   = '0;
            w_upd_last = 1'b0;
        end
`else
        w_upd_last = 1'b1;
`endif
    end

    // The run ends early when the granted zone stops requesting or on abort.
    assign w_req_lost = abort || ((req & r_grant_q) == '0);

    // Phase sequencing and countdown; outputs are derived from the next phase.
    always_comb begin
        w_phase_d = r_phase_q;
        w_grant_d = r_grant_q;
        w_secs_d  = r_secs_q;
        w_last_d  = r_last_q;
        w_done_d  = 1'b0;
        case (r_phase_q)
            c_IDLE: begin
                w_grant_d = '0;
                w_secs_d  = 8'd0;
                if (enable && w_found) begin
                    w_phase_d = c_FILL;
                    w_grant_d = {{(N_ZONES-1){1'b0}}, 1'b1} << w_winner;
                    w_secs_d  = c_FILL_LEN;
                    if (w_upd_last) begin
                        w_last_d = w_winner;
                    end
                end
            end
            c_FILL, c_IRR: begin
                if (w_req_lost) begin
                    // Cleaning always follows a pumping phase, even when cut short.
                    w_phase_d = c_CLEAN;
                    w_secs_d  = c_CLEAN_LEN;
                end else if (tick_1hz) begin
                    if (r_secs_q > 8'd1) begin
                        w_secs_d = r_secs_q - 8'd1;
                    end else if (r_phase_q == c_FILL) begin
                        w_phase_d = c_IRR;
                        w_secs_d  = c_IRR_LEN;
                    end else begin
                        w_phase_d = c_CLEAN;
                        w_secs_d  = c_CLEAN_LEN;
                    end
                end
            end
            default: begin
                if (tick_1hz) begin
                    if (r_secs_q > 8'd1) begin
                        w_secs_d = r_secs_q - 8'd1;
                    end else begin
                        w_phase_d = c_IDLE;
                        w_grant_d = '0;
                        w_secs_d  = 8'd0;
                        w_done_d  = 1'b1;
                    end
                end
            end
        endcase
        w_pump_d  = (w_phase_d == c_FILL) || (w_phase_d == c_IRR);
        w_clean_d = (w_phase_d == c_CLEAN);
    end

    // State and registered outputs.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_q <= c_IDLE;
            r_grant_q <= '0;
            r_secs_q  <= 8'd0;
            r_last_q  <= c_LAST_RST;
            r_done_q  <= 1'b0;
            r_pump_q  <= 1'b0;
            r_clean_q <= 1'b0;
        end else begin
            r_phase_q <= w_phase_d;
            r_grant_q <= w_grant_d;
            r_secs_q  <= w_secs_d;
            r_last_q  <= w_last_d;
            r_done_q  <= w_done_d;
            r_pump_q  <= w_pump_d;
            r_clean_q <= w_clean_d;
        end
    end

    assign grant       = r_grant_q;
    assign pump_on     = r_pump_q;
    assign valve_clean = r_clean_q;
    assign phase       = r_phase_q;
    assign secs_left   = r_secs_q;
    assign done        = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_zone_pump_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_zone_pump_scheduler                                     |
// | Description : Directed vector table plus corner-case sequences for the   |
// |               zone pump scheduler.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_zone_pump_scheduler;

    logic       clk_50mhz;
    logic       rst_n;
    logic       tick_1hz;
    logic       enable;
    logic [3:0] req;
    logic       abort;
    logic [3:0] grant;
    logic       pump_on;
    logic       valve_clean;
    logic [1:0] phase;
    logic [7:0] secs_left;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       tick;
        logic       en;
        logic [3:0] req;
        logic       abort;
        logic [1:0] ph;
        logic [3:0] gr;
        logic [7:0] secs;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    zone_pump_scheduler #(
        .N_ZONES   (4),
        .FILL_SECS (5),
        .IRR_SECS  (10),
        .CLEAN_SECS(3)
    ) u_dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .enable     (enable),
        .req        (req),
        .abort      (abort),
        .grant      (grant),
        .pump_on    (pump_on),
        .valve_clean(valve_clean),
        .phase      (phase),
        .secs_left  (secs_left),
        .done       (done)
    );

    initial begin
        clk_50mhz = 1'b0;
        forever #10 clk_50mhz = ~clk_50mhz;
    end

    function automatic void add(input logic t, input logic e, input logic [3:0] r,
                                input logic a, input logic [1:0] p, input logic [3:0] g,
                                input logic [7:0] s, input logic d);
        vec_t v;
        v.tick = t; v.en = e; v.req = r; v.abort = a;
        v.ph = p; v.gr = g; v.secs = s; v.dn = d;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    // Pump follows FILL/IRRIGATE, clean valve follows CLEAN.
    task automatic chk(input string nm, input logic [1:0] p, input logic [3:0] g,
                       input logic [7:0] s, input logic d);
        logic [16:0] act;
        logic [16:0] exp;
        exp = {p, g, s, (p == 2'b01) || (p == 2'b10), (p == 2'b11), d};
        act = {phase, grant, secs_left, pump_on, valve_clean, done};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got ph=%b gr=%b secs=%0d pump=%b clean=%b done=%b, want ph=%b gr=%b secs=%0d pump=%b clean=%b done=%b",
                     nm, act[16:15], act[14:11], act[10:3], act[2], act[1], act[0],
                     exp[16:15], exp[14:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Pulse the tick every cycle until the phase/secs pair is reached.
    task automatic tick_until(input string nm, input logic [1:0] p, input logic [7:0] s,
                              input int maxc);
        int n;
        n = 0;
        while (!(phase == p && secs_left == s) && n < maxc) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            n++;
        end
        if (!(phase == p && secs_left == s)) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, got ph=%b secs=%0d want ph=%b secs=%0d",
                     nm, phase, secs_left, p, s);
        end
    endtask

    task automatic tick_until_done(input string nm, input int maxc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: timeout waiting for done, phase=%b", nm, phase);
        end
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        req = 4'b0000; enable = 1'b1; tick_1hz = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; tick_1hz = 1'b0; enable = 1'b0; req = 4'b0000; abort = 1'b0;
        #1 rst_n = 1'b0;
        #4;
        chk("reset", 2'b00, 4'b0000, 8'd0, 1'b0);
        #20 rst_n = 1'b1;

        // Full run of zone 0, then enable gating, then a request drop in FILL.
        add(0, 1, 4'b0001, 0, 2'b01, 4'b0001, 8'd5, 0);
        add(0, 1, 4'b0001, 0, 2'b01, 4'b0001, 8'd5, 0);
        for (int s = 4; s >= 1; s--) add(1, 1, 4'b0001, 0, 2'b01, 4'b0001, 8'(s), 0);
        add(1, 1, 4'b0001, 0, 2'b10, 4'b0001, 8'd10, 0);
        for (int s = 9; s >= 1; s--) add(1, 1, 4'b0001, 0, 2'b10, 4'b0001, 8'(s), 0);
        add(1, 1, 4'b0001, 0, 2'b11, 4'b0001, 8'd3, 0);
        add(1, 1, 4'b0001, 0, 2'b11, 4'b0001, 8'd2, 0);
        add(1, 1, 4'b0001, 0, 2'b11, 4'b0001, 8'd1, 0);
        add(1, 1, 4'b0000, 0, 2'b00, 4'b0000, 8'd0, 1);
        add(1, 1, 4'b0000, 0, 2'b00, 4'b0000, 8'd0, 0);
        add(0, 0, 4'b0010, 0, 2'b00, 4'b0000, 8'd0, 0);
        add(0, 1, 4'b0010, 0, 2'b01, 4'b0010, 8'd5, 0);
        add(1, 1, 4'b0000, 0, 2'b11, 4'b0010, 8'd3, 0);
        add(1, 1, 4'b0000, 0, 2'b11, 4'b0010, 8'd2, 0);
        add(1, 1, 4'b0000, 0, 2'b11, 4'b0010, 8'd1, 0);
        add(1, 1, 4'b0000, 0, 2'b00, 4'b0000, 8'd0, 1);
        add(0, 1, 4'b0000, 0, 2'b00, 4'b0000, 8'd0, 0);

        foreach (tbl[i]) begin
            tick_1hz = tbl[i].tick;
            enable   = tbl[i].en;
            req      = tbl[i].req;
            abort    = tbl[i].abort;
            step();
            chk($sformatf("vec%0d", i), tbl[i].ph, tbl[i].gr, tbl[i].secs, tbl[i].dn);
        end
        tick_1hz = 1'b0; abort = 1'b0;

        // Round-robin over three runs with all zones requesting.
        do_reset();
        req = 4'b1111;
        step();
        chk("rr_grant0", 2'b01, 4'b0001, 8'd5, 1'b0);
        tick_until("rr_clean0", 2'b11, 8'd3, 40);
        chk("rr_clean0_out", 2'b11, 4'b0001, 8'd3, 1'b0);
        tick_until_done("rr_done0", 10);
        chk("rr_idle0", 2'b00, 4'b0000, 8'd0, 1'b1);
        step();
        chk("rr_grant1", 2'b01, 4'b0010, 8'd5, 1'b0);
        tick_until("rr_clean1", 2'b11, 8'd3, 40);
        chk("rr_clean1_out", 2'b11, 4'b0010, 8'd3, 1'b0);
        tick_until_done("rr_done1", 10);
        step();
        chk("rr_grant2", 2'b01, 4'b0100, 8'd5, 1'b0);
        req = 4'b0000;
        step();
        tick_until_done("rr_done2", 10);

        // Abort in IRRIGATE at 7 s left; abort inside CLEAN is ignored.
        do_reset();
        req = 4'b0001;
        step();
        tick_until("abort_reach", 2'b10, 8'd7, 40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_irr", 2'b11, 4'b0001, 8'd3, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_clean", 2'b11, 4'b0001, 8'd3, 1'b0);
        tick_1hz = 1'b1; step();
        chk("abort_t1", 2'b11, 4'b0001, 8'd2, 1'b0);
        step();
        chk("abort_t2", 2'b11, 4'b0001, 8'd1, 1'b0);
        step();
        tick_1hz = 1'b0;
        chk("abort_done", 2'b00, 4'b0000, 8'd0, 1'b1);
        req = 4'b0000;
        step();
        chk("abort_idle", 2'b00, 4'b0000, 8'd0, 1'b0);

        // Request drop and last FILL tick in the same cycle go to CLEAN.
        req = 4'b0001;
        step();
        chk("drop_grant", 2'b01, 4'b0010 >> 1, 8'd5, 1'b0);
        tick_until("drop_reach", 2'b01, 8'd1, 10);
        tick_1hz = 1'b1; req = 4'b0000;
        step();
        tick_1hz = 1'b0;
        chk("drop_tick", 2'b11, 4'b0001, 8'd3, 1'b0);
        tick_until_done("drop_done", 10);

        // Asynchronous reset in IRRIGATE, then the pointer restarts at zone 0.
        req = 4'b0001;
        step();
        tick_until("rst_reach", 2'b10, 8'd10, 10);
        #5 rst_n = 1'b0;
        #2;
        chk("rst_async", 2'b00, 4'b0000, 8'd0, 1'b0);
        #4 rst_n = 1'b1;
        req = 4'b0010;
        step();
        chk("rst_regrant", 2'b01, 4'b0010, 8'd5, 1'b0);

        // Zone 0 preference: last winner is zone 0, zones 0 and 1 request.
        do_reset();
        req = 4'b0001;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tick_until_done("prio_done", 10);
        req = 4'b0011;
        step();
`ifdef PRIORITY_ZONE0_EN
        chk("prio_grant", 2'b01, 4'b0001, 8'd5, 1'b0);
`else
        chk("prio_grant", 2'b01, 4'b0010, 8'd5, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
